// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module  : seg_pkg
// Purpose : Shared constants for the 7-segment digit driver.
//           - SEG_OFF   : all segments dark (active-low encoding)
//           - SEG_TABLE : hex nibble -> active-low {g,f,e,d,c,b,a}
//           - clog2     : ceiling log2 for constant width derivation
// Revision: 1.0 - initial release
// ============================================================================
package seg_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Indexed by the hex nibble; entry 15 is listed first in the concatenation.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_digit_driver_hex.sv
`default_nettype none
// ============================================================================
// Module  : hex_to_seg7
// Purpose : Purely combinational hex-digit to active-low 7-segment decoder.
// Ports   : digit (in, 4)  - hex nibble
//           seg_n (out, 7) - segments {g,f,e,d,c,b,a}, active-low
// Revision: 1.0 - initial release
// ============================================================================
module hex_to_seg7
    import seg_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg_n
);

    assign seg_n = SEG_TABLE[digit];

endmodule
`default_nettype wire

// File: rtl/seg_digit_driver.sv
`default_nettype none
// ============================================================================
// Module  : seg_digit_driver
// Purpose : Drives a multiplexed 7-segment display from a one-hot rotating
//           digit select. Double-buffered digit bank (shadow/active) with
//           commit at frame start, anti-ghost blanking after each select
//           change, leading-zero suppression and a sticky bad-select flag.
// Ports   : clk, rst (sync, active-high)
//           sel      (in, DIGITS)    one-hot digit select
//           value    (in, 4*DIGITS)  hex digits, digit i at [4i+3:4i]
//           dp       (in, DIGITS)    decimal points, active-high
//           blank_lz (in)            suppress leading zeros
//           update   (in)            load value/dp into shadow bank
//           pending  (out)           shadow holds uncommitted data
//           sel_err  (out)           sticky: sel was not one-hot
//           an_n     (out, DIGITS)   anodes, active-low
//           seg_n    (out, 7)        segments {g..a}, active-low
//           dp_n     (out)           decimal point, active-low
// Revision: 1.0 - initial release
// ============================================================================
module seg_digit_driver
    import seg_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int BLANK_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIGITS-1:0]     sel,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  blank_lz,
    input  logic                  update,
    output logic                  pending,
    output logic                  sel_err,
    output logic [DIGITS-1:0]     an_n,
    output logic [6:0]            seg_n,
    output logic                  dp_n
);

    // Counter width; a zero-width counter is avoided when blanking is disabled.
    localparam int CW = (clog2(BLANK_CYCLES + 1) > 0) ? clog2(BLANK_CYCLES + 1) : 1;
    localparam logic              BLANK_EN  = (BLANK_CYCLES != 0);
    localparam logic [DIGITS-1:0] FRAME_SEL = DIGITS'(1);

    logic [DIGITS-1:0]   r_prev_sel;
    logic [CW-1:0]       r_blank_cnt;
    logic [4*DIGITS-1:0] r_shadow_val;
    logic [DIGITS-1:0]   r_shadow_dp;
    logic [4*DIGITS-1:0] r_active_val;
    logic [DIGITS-1:0]   r_active_dp;

    logic                w_chg;
    logic                w_onehot;
    logic                w_commit;
    logic                w_blank_now;
    logic [4*DIGITS-1:0] w_next_val;
    logic [DIGITS-1:0]   w_next_dp;
    logic [DIGITS-1:0]   w_lz;
    logic                w_zero_run;
    logic [3:0]          w_nib;
    logic                w_dp_sel;
    logic                w_digit_blank;
    logic [6:0]          w_seg_raw;

    assign w_chg    = (sel != r_prev_sel);
    assign w_onehot = $onehot(sel);
    assign w_commit = w_chg && (sel == FRAME_SEL);

    // Bank contents as they will be after this edge. Decoding from this view
    // keeps the first digit of a new frame consistent with the rest of the
    // frame even when blanking is disabled; an update coinciding with a commit
    // bypasses the shadow bank.
    assign w_next_val = w_commit ? (update ? value : r_shadow_val) : r_active_val;
    assign w_next_dp  = w_commit ? (update ? dp    : r_shadow_dp)  : r_active_dp;

    // Output goes dark on a bad select, on the change itself (when blanking is
    // enabled), and while the counter has more than one cycle left. Releasing
    // at count 1 makes the digit appear exactly BLANK_CYCLES cycles after the
    // first dark cycle.
    assign w_blank_now = !w_onehot
                       || (w_chg && BLANK_EN)
                       || (!w_chg && (r_blank_cnt > CW'(1)));

    // Leading-zero mask: scan from the most significant digit down while the
    // digits stay zero. Digit 0 is always shown.
    always_comb begin
        w_zero_run = 1'b1;
        w_lz       = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_zero_run = w_zero_run && (w_next_val[4*i +: 4] == 4'h0);
            w_lz[i]    = blank_lz && w_zero_run && (i != 0);
        end
    end

    // Select the digit named by sel. With an invalid sel the result is unused.
    always_comb begin
        w_nib         = 4'h0;
        w_dp_sel      = 1'b0;
        w_digit_blank = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (sel[i]) begin
                w_nib         = w_next_val[4*i +: 4];
                w_dp_sel      = w_next_dp[i];
                w_digit_blank = w_lz[i];
            end
        end
    end

    hex_to_seg7 u_hex_to_seg7 (
        .digit (w_nib),
        .seg_n (w_seg_raw)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_sel   <= '0;
            r_blank_cnt  <= '0;
            r_shadow_val <= '0;
            r_shadow_dp  <= '0;
            r_active_val <= '0;
            r_active_dp  <= '0;
            pending      <= 1'b0;
            sel_err      <= 1'b0;
            an_n         <= '1;
            seg_n        <= SEG_OFF;
            dp_n         <= 1'b1;
        end else begin
            r_prev_sel <= sel;

            if (w_chg) begin
                r_blank_cnt <= CW'(BLANK_CYCLES);
            end else if (r_blank_cnt != '0) begin
                r_blank_cnt <= r_blank_cnt - CW'(1);
            end

            if (update) begin
                r_shadow_val <= value;
                r_shadow_dp  <= dp;
            end

            if (w_commit) begin
                r_active_val <= w_next_val;
                r_active_dp  <= w_next_dp;
                pending      <= 1'b0;
            end else if (update) begin
                pending      <= 1'b1;
            end

            if (!w_onehot) begin
                sel_err <= 1'b1;
            end

            if (w_blank_now) begin
                an_n  <= '1;
                seg_n <= SEG_OFF;
                dp_n  <= 1'b1;
            end else begin
                an_n  <= ~sel;
                seg_n <= w_digit_blank ? SEG_OFF : w_seg_raw;
                dp_n  <= ~w_dp_sel;
            end
        end
    end

endmodule
`default_nettype wire
